// File: rtl/logic_op_sequencer_if.sv
// Command and logic-unit bus for logic_op_sequencer.
// The slave side is the sequencer. The master side is the command source
// together with the logic units that return unit_res.
interface logic_op_sequencer_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] unit_in;
    logic [W-1:0] unit_sv;
    logic [3:0]   unit_en;
    logic [W-1:0] unit_res;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, unit_res,
        output cmd_ready, unit_in, unit_sv, unit_en
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, unit_res,
        input  cmd_ready, unit_in, unit_sv, unit_en
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: accepts LOAD/AND/OR/NOR/XOR/CLEAR commands and drives
// the shared bitwise logic units. It holds the unit enable for EXEC_CYCLES
// cycles, then writes the combined unit result back into the accumulator.
// Optional feature: define SEQ_ZERO_FLAG_EN to add a registered zero flag (zf).
module logic_op_sequencer #(
    parameter int W           = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_op_sequencer_if.slave   bus,
    output logic [W-1:0]          acc,
    output logic                  busy,
    output logic                  done,
`ifdef SEQ_ZERO_FLAG_EN
    output logic                  err,
    output logic                  zf
`else
    output logic                  err
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    // The counter is loaded with EXEC_CYCLES-1 and runs down to zero.
    // This gives EXEC_CYCLES cycles in EXEC.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t       state_q;
    logic [2:0]   op_q;
    logic [W-1:0] opnd_q;
    logic [3:0]   cnt_q;
    logic [W-1:0] acc_q, acc_d;
    logic [3:0]   unit_en_q;
    logic [W-1:0] unit_in_q;
    logic         busy_q, done_q, err_q, ready_q;
    logic         legal;
`ifdef SEQ_ZERO_FLAG_EN
    logic         zf_q;
`endif

    // One-hot unit select. LOAD, CLEAR and illegal opcodes enable no unit.
    function automatic logic [3:0] en_onehot(input logic [2:0] op);
        case (op)
            OP_AND:  return 4'b0001;
            OP_OR:   return 4'b0010;
            OP_NOR:  return 4'b0100;
            OP_XOR:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    assign legal = (op_q <= OP_CLEAR);

    // Write-back value for the latched op. Illegal opcodes keep the accumulator.
    always_comb begin
        acc_d = acc_q;
        case (op_q)
            OP_AND, OP_OR, OP_NOR, OP_XOR: acc_d = bus.unit_res;
            OP_LOAD:                       acc_d = opnd_q;
            OP_CLEAR:                      acc_d = '0;
            default:                       acc_d = acc_q;
        endcase
    end

    // Sequencer FSM. Every output is a register, so no input reaches an
    // output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            unit_en_q <= '0;
            unit_in_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
`ifdef SEQ_ZERO_FLAG_EN
            zf_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q      <= bus.cmd_op;
                        opnd_q    <= bus.cmd_data;
                        cnt_q     <= CNT_INIT;
                        unit_en_q <= en_onehot(bus.cmd_op);
                        unit_in_q <= bus.cmd_data;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        acc_q     <= acc_d;
`ifdef SEQ_ZERO_FLAG_EN
                        if (legal) zf_q <= (acc_d == '0);
`endif
                        unit_en_q <= '0;
                        unit_in_q <= '0;
                        done_q    <= legal;
                        err_q     <= !legal;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.unit_in   = unit_in_q;
    assign bus.unit_en   = unit_en_q;
    assign bus.unit_sv   = acc_q;
    assign acc           = acc_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
`ifdef SEQ_ZERO_FLAG_EN
    assign zf            = zf_q;
`endif
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer.
// u1 runs with EXEC_CYCLES=1 and u4 runs with EXEC_CYCLES=4.
// Each instance has its own behavioural model of the AND/OR/NOR/XOR units.
module tb_logic_op_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic_op_sequencer_if #(.W(8)) i1 ();
    logic_op_sequencer_if #(.W(8)) i4 ();

    logic [7:0] acc1, acc4;
    logic       busy1, busy4, done1, done4, err1, err4;
`ifdef SEQ_ZERO_FLAG_EN
    logic       zf1, zf4;
`endif

    logic_op_sequencer #(.W(8), .EXEC_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(i1), .acc(acc1), .busy(busy1),
`ifdef SEQ_ZERO_FLAG_EN
        .done(done1), .err(err1), .zf(zf1)
`else
        .done(done1), .err(err1)
`endif
    );

    logic_op_sequencer #(.W(8), .EXEC_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(i4), .acc(acc4), .busy(busy4),
`ifdef SEQ_ZERO_FLAG_EN
        .done(done4), .err(err4), .zf(zf4)
`else
        .done(done4), .err(err4)
`endif
    );

    // Model of the logic units. A disabled unit contributes 0 to the OR.
    function automatic logic [7:0] umodel(input logic [3:0] en, input logic [7:0] a, input logic [7:0] sv);
        logic [7:0] r;
        r = 8'h00;
        if (en[0]) r = r | (a & sv);
        if (en[1]) r = r | (a | sv);
        if (en[2]) r = r | ~(a | sv);
        if (en[3]) r = r | (a ^ sv);
        return r;
    endfunction

    assign i1.unit_res = umodel(i1.unit_en, i1.unit_in, i1.unit_sv);
    assign i4.unit_res = umodel(i4.unit_en, i4.unit_in, i4.unit_sv);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Issue one command on u1 and check it through EXEC (EXEC_CYCLES=1) and DONE.
    task automatic run1(input string tag, input logic [2:0] op, input logic [7:0] d,
                        input logic [3:0] en_exp, input logic [7:0] acc_exp, input logic is_err);
        i1.cmd_valid = 1'b1; i1.cmd_op = op; i1.cmd_data = d;
        cyc();
        i1.cmd_valid = 1'b0;
        chk({tag, "_exec_en"}, 16'(i1.unit_en), 16'(en_exp));
        chk({tag, "_exec_in"}, 16'(i1.unit_in), 16'(d));
        chk({tag, "_exec_busy"}, 16'(busy1), 16'd1);
        chk({tag, "_exec_rdy"}, 16'(i1.cmd_ready), 16'd0);
        cyc();
        chk({tag, "_acc"}, 16'(acc1), 16'(acc_exp));
        chk({tag, "_done"}, 16'(done1), 16'(!is_err));
        chk({tag, "_err"}, 16'(err1), 16'(is_err));
        chk({tag, "_done_en"}, 16'(i1.unit_en), 16'd0);
        chk({tag, "_done_in"}, 16'(i1.unit_in), 16'd0);
        cyc();
        chk({tag, "_idle_done"}, 16'({done1, err1}), 16'd0);
        chk({tag, "_idle_rdy"}, 16'(i1.cmd_ready), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        i1.cmd_valid = 1'b0; i1.cmd_op = 3'd0; i1.cmd_data = 8'h00;
        i4.cmd_valid = 1'b0; i4.cmd_op = 3'd0; i4.cmd_data = 8'h00;
        cyc(); cyc();
        chk("rst_acc", 16'(acc1), 16'h0);
        chk("rst_rdy", 16'(i1.cmd_ready), 16'd1);
        chk("rst_flags", 16'({busy1, done1, err1}), 16'd0);
        chk("rst_en_in", 16'({i1.unit_en, i1.unit_in}), 16'd0);
        chk("rst_u4", 16'({busy4, done4, err4, i4.cmd_ready}), 16'b0001);
`ifdef SEQ_ZERO_FLAG_EN
        chk("rst_zf", 16'(zf1), 16'd1);
`endif
        rst_n = 1'b1;
        cyc();

        // u1, EXEC_CYCLES=1
        run1("load_a5", 3'd0, 8'hA5, 4'b0000, 8'hA5, 1'b0);
        // NOR 0x0F with SV 0xA5: ~(0xAF) = 0x50
        i1.cmd_valid = 1'b1; i1.cmd_op = 3'd3; i1.cmd_data = 8'h0F;
        cyc();
        i1.cmd_valid = 1'b0;
        chk("nor_sv", 16'(i1.unit_sv), 16'hA5);
        chk("nor_en", 16'(i1.unit_en), 16'b0100);
        chk("nor_in", 16'(i1.unit_in), 16'h0F);
        cyc();
        chk("nor_acc", 16'(acc1), 16'h50);
        chk("nor_done", 16'(done1), 16'd1);
`ifdef SEQ_ZERO_FLAG_EN
        chk("nor_zf", 16'(zf1), 16'd0);
`endif
        cyc();
        run1("and_00", 3'd1, 8'h00, 4'b0001, 8'h00, 1'b0);
`ifdef SEQ_ZERO_FLAG_EN
        chk("and_zf", 16'(zf1), 16'd1);
`endif
        run1("load_3c", 3'd0, 8'h3C, 4'b0000, 8'h3C, 1'b0);
        run1("illegal7", 3'd7, 8'hFF, 4'b0000, 8'h3C, 1'b1);
        run1("illegal6", 3'd6, 8'h00, 4'b0000, 8'h3C, 1'b1);
`ifdef SEQ_ZERO_FLAG_EN
        chk("illegal_zf", 16'(zf1), 16'd0);
`endif
        run1("or_03", 3'd2, 8'h03, 4'b0010, 8'h3F, 1'b0);
        run1("xor_f0", 3'd4, 8'hF0, 4'b1000, 8'hCF, 1'b0);
        run1("clear", 3'd5, 8'h77, 4'b0000, 8'h00, 1'b0);

        // u4, EXEC_CYCLES=4: XOR 0xFF with acc 0, cmd_valid held for a LOAD 0x11
        i4.cmd_valid = 1'b1; i4.cmd_op = 3'd4; i4.cmd_data = 8'hFF;
        cyc();                                   // accepted at edge E0
        i4.cmd_op = 3'd0; i4.cmd_data = 8'h11;   // queued second command
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("x4_en_%0d", k), 16'(i4.unit_en), 16'b1000);
            chk($sformatf("x4_in_%0d", k), 16'(i4.unit_in), 16'hFF);
            chk($sformatf("x4_rdy_%0d", k), 16'(i4.cmd_ready), 16'd0);
            chk($sformatf("x4_acc_%0d", k), 16'(acc4), 16'h00);
            cyc();
        end
        chk("x4_done", 16'(done4), 16'd1);
        chk("x4_acc", 16'(acc4), 16'hFF);
        chk("x4_en_off", 16'(i4.unit_en), 16'd0);
        chk("x4_rdy_done", 16'(i4.cmd_ready), 16'd0);
        cyc();
        chk("x4_rdy_back", 16'(i4.cmd_ready), 16'd1);
        chk("x4_idle", 16'({busy4, done4}), 16'd0);
        cyc();                                   // edge E0+6: second command taken
        i4.cmd_valid = 1'b0;
        chk("q2_busy", 16'(busy4), 16'd1);
        chk("q2_in", 16'(i4.unit_in), 16'h11);
        chk("q2_en", 16'(i4.unit_en), 16'd0);
        repeat (4) cyc();
        chk("q2_done", 16'(done4), 16'd1);
        chk("q2_acc", 16'(acc4), 16'h11);
        cyc();

        // u4: reset asserted in the 2nd EXEC cycle of an OR
        i4.cmd_valid = 1'b1; i4.cmd_op = 3'd2; i4.cmd_data = 8'h0F;
        cyc();
        i4.cmd_valid = 1'b0;
        cyc();
        chk("rm_pre_en", 16'(i4.unit_en), 16'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_acc", 16'(acc4), 16'h00);
        chk("rm_flags", 16'({busy4, done4, err4}), 16'd0);
        chk("rm_en_in", 16'({i4.unit_en, i4.unit_in}), 16'd0);
        chk("rm_rdy", 16'(i4.cmd_ready), 16'd1);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("rm_nodone_%0d", k), 16'({done4, busy4}), 16'd0);
        end
        chk("rm_acc_after", 16'(acc4), 16'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
